te_mux_arbiter: RTL and testbench
=================================

TE_MUX_ARBITER -- requirements
Module: te_mux_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 16, maximum grant tenure in cycles; legal range 1..255.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_b  input  1  asynchronous active-low reset.
REQ-004 req  input  4  request per requester 0..3, level, held until grant ends.
REQ-005 done  input  4  per-requester end-of-transaction strobe, sampled only for current owner.
REQ-006 grant  output  4  registered one-hot grant, all-zero when idle.
REQ-007 data_sel  output  2  registered select driving the shared 4:1 datapath multiplexer.
REQ-008 busy  output  1  registered, high while any grant asserted.
REQ-009 timeout  output  1  registered one-cycle pulse on forced release.

Function
REQ-010 Two states SHALL exist: IDLE (no owner) and OWN (one owner, grant[owner]=1).
REQ-011 IDLE with req==0 SHALL stay IDLE; grant=0, busy=0, data_sel holds the last owner index.
REQ-012 IDLE with req!=0 SHALL select the winner by round-robin search starting at index ptr, ptr+1, ... mod 4.
REQ-013 The winner's grant bit, data_sel=winner index and busy=1 SHALL appear on the cycle after req is sampled (1-cycle latency); state becomes OWN.
REQ-014 A hold counter SHALL clear to 0 on each new grant and increment by 1 each OWN cycle.
REQ-015 OWN SHALL end (release) when done[owner]=1, or req[owner]=0, or hold counter == MAX_HOLD-1, whichever comes first.
REQ-016 done bits of non-owners SHALL be ignored.
REQ-017 On release ptr SHALL become (owner+1) mod 4, so the released owner has lowest priority next.
REQ-018 On release with other or same requests pending (excluding a requester whose req is low), arbitration SHALL run in the same cycle using the updated ptr; the new grant SHALL appear on the next cycle with no idle gap.
REQ-019 On release with no pending request, the next cycle SHALL be IDLE with grant=0, busy=0.
REQ-020 timeout SHALL pulse high for exactly one cycle, the cycle after a release caused solely by the hold counter (done[owner]=0 and req[owner]=1).
REQ-021 If done[owner] and counter limit coincide, release SHALL count as normal (timeout=0).
REQ-022 grant SHALL never have more than one bit set; data_sel SHALL equal the index of the set bit whenever grant!=0.
REQ-023 data_sel SHALL only change in the same cycle grant changes to a new owner.
REQ-024 MAX_HOLD=1 SHALL give single-cycle tenures; with all four requesting, grants rotate 0,1,2,3,0... every cycle with timeout pulse each cycle.

Reset
REQ-025 rst_b low SHALL immediately force grant=0, data_sel=0, busy=0, timeout=0, ptr=0, hold counter=0, state IDLE, regardless of clk.
REQ-026 Reset asserted mid-tenure SHALL abort the tenure; after deassertion arbitration restarts from ptr=0 on the first rising edge with req sampled.

Verification
REQ-027 Reset release, req=4'b1010 held -> cycle+1 grant=4'b0010, data_sel=1, busy=1.
REQ-028 req=4'b1111 held, each owner asserts done on its 3rd tenure cycle -> grant sequence 0,1,2,3,0 each 3 cycles long, no idle cycle between, timeout never high.
REQ-029 MAX_HOLD=16, req=4'b0100 held, done never -> grant=4'b0100 for 16 cycles, timeout pulse after release, then requester 2 re-granted next cycle (only requester).
REQ-030 Owner 0 holding, done[1] pulsed -> no effect; owner 0 drops req -> grant=0, busy=0 next cycle, data_sel stays 0.
REQ-031 rst_b asserted while grant=4'b1000 -> grant=0, data_sel=0 immediately; after release with req=4'b1001, grant=4'b0001.
REQ-032 done[owner] and hold limit in same cycle with req=4'b0011, owner 0 -> timeout=0, next grant=4'b0010.

Source files
------------

// File: rtl/te_mux_arbiter.sv
// te_mux_arbiter
//   Four-requester round-robin arbiter with bounded grant tenure. The grant,
//   the shared-datapath mux select, busy and timeout are all registered.
//   A tenure ends on done from the owner, when the owner drops its request,
//   or when the hold limit is reached. When a tenure ends, re-arbitration
//   happens in the same cycle, so the next owner's grant follows with no
//   idle gap.
//
// Ports
//   clk_i       : single clock; all state updates on the rising edge
//   rst_b_i     : asynchronous active-low reset
//   req_i[3:0]  : level request per requester, held until its grant ends
//   done_i[3:0] : end-of-transaction strobe; only the current owner's bit is used
//   grant_o     : one-hot grant, all zero when idle
//   data_sel_o  : index of the current/last owner, drives the 4:1 datapath mux
//   busy_o      : high while any grant is asserted
//   timeout_o   : one-cycle pulse after a release forced only by the hold limit
module te_mux_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk_i,
    input  logic       rst_b_i,
    input  logic [3:0] req_i,
    input  logic [3:0] done_i,
    output logic [3:0] grant_o,
    output logic [1:0] data_sel_o,
    output logic       busy_o,
    output logic       timeout_o
);

    typedef enum logic {
        S_IDLE,
        S_OWN
    } state_e;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_e     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] hold_q, hold_d;
    logic [3:0] grant_q, grant_d;
    logic       busy_q, busy_d;
    logic       timeout_q, timeout_d;

    logic       release_w;
    logic       try_arb;
    logic [1:0] arb_base;
    logic [1:0] arb_idx;
    logic [1:0] cand;
    logic       arb_found;

    assign release_w = (state_q == S_OWN) &&
                       (done_i[owner_q] || !req_i[owner_q] || (hold_q == HOLD_LAST));

    // On release the search starts just past the outgoing owner, so the
    // outgoing owner has the lowest priority for this same-cycle arbitration.
    assign try_arb  = (state_q == S_IDLE) || release_w;
    assign arb_base = release_w ? owner_q + 2'd1 : ptr_q;

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            cand = arb_base + 2'(i);
            if (!arb_found && req_i[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_b_i) begin
        if (!rst_b_i) begin
            state_q   <= S_IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (arb_found) state_d = S_OWN;
            S_OWN:  if (release_w) state_d = arb_found ? S_OWN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        grant_d   = grant_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        if (state_q == S_OWN) begin
            hold_d = hold_q + 8'd1;
            if (release_w) begin
                ptr_d     = owner_q + 2'd1;
                // Timeout only when the hold limit alone forced the release.
                timeout_d = !done_i[owner_q] && req_i[owner_q];
                grant_d   = '0;
                busy_d    = 1'b0;
            end
        end
        if (try_arb && arb_found) begin
            owner_d = arb_idx;
            grant_d = 4'b0001 << arb_idx;
            busy_d  = 1'b1;
            hold_d  = '0;
        end
    end

    assign grant_o    = grant_q;
    assign data_sel_o = owner_q;
    assign busy_o     = busy_q;
    assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_te_mux_arbiter.sv
// tb_te_mux_arbiter
//   Directed bench for te_mux_arbiter. Two instances: one with the default
//   MAX_HOLD of 16 and one with MAX_HOLD=1. Expected outputs are queued when
//   each step is driven and popped after the following rising edge.
module tb_te_mux_arbiter;

    logic       clk = 1'b0;
    logic       rst_b, rst1_b;
    logic [3:0] req, done, req1, done1;
    logic [3:0] grant, grant1;
    logic [1:0] data_sel, data_sel1;
    logic       busy, busy1, timeout, timeout1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0] g;
        logic [1:0] s;
        logic       b;
        logic       t;
        logic       which;
        string      tag;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    te_mux_arbiter dut (
        .clk_i      (clk),
        .rst_b_i    (rst_b),
        .req_i      (req),
        .done_i     (done),
        .grant_o    (grant),
        .data_sel_o (data_sel),
        .busy_o     (busy),
        .timeout_o  (timeout)
    );

    te_mux_arbiter #(.MAX_HOLD(1)) dut1 (
        .clk_i      (clk),
        .rst_b_i    (rst1_b),
        .req_i      (req1),
        .done_i     (done1),
        .grant_o    (grant1),
        .data_sel_o (data_sel1),
        .busy_o     (busy1),
        .timeout_o  (timeout1)
    );

    task automatic push(input logic [3:0] g, input logic [1:0] s, input logic b,
                        input logic t, input logic which, input string tag);
        exp_t e;
        e.g = g; e.s = s; e.b = b; e.t = t; e.which = which; e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic check_front();
        exp_t e;
        logic [3:0] ag;
        logic [1:0] as;
        logic       ab, at;
        n_tests++;
        assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL scoreboard_empty got %0d entries exp >0", exp_q.size());
        end
        if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            ag = e.which ? grant1    : grant;
            as = e.which ? data_sel1 : data_sel;
            ab = e.which ? busy1     : busy;
            at = e.which ? timeout1  : timeout;
            n_tests++;
            assert (ag === e.g) else begin
                n_fail++;
                $error("FAIL %s grant got %b exp %b", e.tag, ag, e.g);
            end
            n_tests++;
            assert (as === e.s) else begin
                n_fail++;
                $error("FAIL %s data_sel got %0d exp %0d", e.tag, as, e.s);
            end
            n_tests++;
            assert (ab === e.b) else begin
                n_fail++;
                $error("FAIL %s busy got %b exp %b", e.tag, ab, e.b);
            end
            n_tests++;
            assert (at === e.t) else begin
                n_fail++;
                $error("FAIL %s timeout got %b exp %b", e.tag, at, e.t);
            end
        end
    endtask

    // Drive one cycle on the default instance and check the outputs it
    // registers at the next rising edge.
    task automatic step(input logic [3:0] r, input logic [3:0] d, input logic [3:0] g,
                        input logic [1:0] s, input logic b, input logic t, input string tag);
        req  = r;
        done = d;
        push(g, s, b, t, 1'b0, tag);
        @(posedge clk);
        #1;
        check_front();
    endtask

    task automatic step1(input logic [3:0] r, input logic [3:0] g, input logic [1:0] s,
                         input logic b, input logic t, input string tag);
        req1  = r;
        done1 = 4'b0000;
        push(g, s, b, t, 1'b1, tag);
        @(posedge clk);
        #1;
        check_front();
    endtask

    initial begin
        logic [3:0] one;
        logic [1:0] own, nxt;
        one    = 4'b0001;
        rst_b  = 1'b0;
        rst1_b = 1'b0;
        req    = '0;
        done   = '0;
        req1   = '0;
        done1  = '0;

        // Reset values, no clock edge yet
        #1;
        push(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, "reset");
        check_front();
        push(4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, "reset_hold1");
        check_front();

        @(posedge clk);
        #1;
        rst_b = 1'b1;

        step(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "idle_no_req");

        // First arbitration from ptr 0
        step(4'b1010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0, "first_grant");
        // done from owner 1: search starts at 2, requester 3 wins with no gap
        step(4'b1010, 4'b0010, 4'b1000, 2'd3, 1'b1, 1'b0, "done_handoff");
        // owner 3 drops req, nothing pending: idle, data_sel keeps 3
        step(4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0, "drop_to_idle");
        step(4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0, "idle_sel_hold");

        // All requesting, each owner signals done on its third tenure cycle
        step(4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, "rr_start");
        for (int k = 0; k < 5; k++) begin
            own = 2'(k);
            nxt = 2'(k + 1);
            for (int c = 0; c < 3; c++) begin
                if (c < 2)
                    step(4'b1111, 4'b0000, one << own, own, 1'b1, 1'b0, "rr_hold");
                else
                    step(4'b1111, one << own, one << nxt, nxt, 1'b1, 1'b0, "rr_next");
            end
        end
        step(4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, "rr_end_idle");

        // Hold limit with a single requester (ptr is 2)
        step(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0, "hold_start");
        for (int j = 1; j <= 15; j++)
            step(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0, "hold_run");
        step(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b1, "hold_timeout");
        step(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0, "hold_regrant");
        step(4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, "hold_drop");

        // Foreign done ignored, then owner 0 drops req (ptr is 3)
        step(4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, "own0_grant");
        step(4'b0001, 4'b0010, 4'b0001, 2'd0, 1'b1, 1'b0, "foreign_done");
        step(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "own0_drop");

        // done and hold limit in the same cycle (ptr is 1)
        step(4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0, "coin_g1");
        step(4'b0011, 4'b0010, 4'b0001, 2'd0, 1'b1, 1'b0, "coin_g0");
        for (int j = 1; j <= 15; j++)
            step(4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, "coin_run");
        step(4'b0011, 4'b0001, 4'b0010, 2'd1, 1'b1, 1'b0, "coin_release");
        step(4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, "coin_idle");

        // Asynchronous reset mid-tenure (ptr is 2)
        step(4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0, "pre_reset_grant");
        #3;
        rst_b = 1'b0;
        req   = 4'b1001;
        #1;
        push(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, "async_reset");
        check_front();
        @(posedge clk);
        #1;
        push(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, "reset_held");
        check_front();
        rst_b = 1'b1;
        step(4'b1001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, "post_reset_grant");
        step(4'b1001, 4'b0001, 4'b1000, 2'd3, 1'b1, 1'b0, "post_reset_next");
        step(4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0, "post_reset_idle");

        // MAX_HOLD=1: single-cycle tenures rotating with a timeout each cycle
        rst1_b = 1'b1;
        for (int k = 0; k < 8; k++) begin
            own = 2'(k);
            step1(4'b1111, one << own, own, 1'b1, (k > 0), "mh1_rotate");
        end
        step1(4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0, "mh1_drop");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
